alu_seq: RTL

Parametrised, registered successor to the CPU's combinational 8-bit ALU. It takes an operand pair and a 4-bit opcode over a valid/ready handshake and returns a registered result with Z/C/N/V flags. It adds subtract, logic, shift and an optional iterative multiply. It sits between the accumulator/operand-fetch stage and the accumulator write-back in the datapath.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mul_iter.sv | 55 +++++
 rtl/alu_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU (alu_seq).
//   - opcode constants OP_NOP..OP_MUL (0xC..0xF are illegal)
//   - controller state enum IDLE/BUSY/DONE
//   - bit positions of the {Z, C, N, V} flag vector
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_PASS = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_ADC  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_SAR  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          load a/b and begin (ignored state is overwritten)
//   a, b           WIDTH-bit unsigned operands
//   done           one-cycle pulse once WIDTH iterations have completed
//   product        2*WIDTH-bit result, valid while done is high
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic                 running;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      product <= '0;
    end else if (running) begin
      // done is visible for exactly one cycle after the last iteration
      if (cnt == CW'(WIDTH)) begin
        running <= 1'b0;
      end else begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
    end
  end

  assign done = running && (cnt == CW'(WIDTH));

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake on both sides.
// Optional feature macro: ALU_MUL_EN (builds the iterative multiplier, op 0xB).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; op/accum/alu_in/carry_in sampled on accept
//   out_valid/out_ready result handshake; result registers hold until consumed
//   alu_out, alu_out_hi result (low/high half; high half only nonzero for MUL)
//   flags               {Z, C, N, V}
//   err                 accepted opcode was illegal
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] alu_in,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic [3:0]       flags,
  output logic             err
);

  state_t state, state_next;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   a_x, b_x, wide;
  logic [WIDTH-1:0] res;
  logic             c_f, v_f, ill;
  logic [3:0]       flags_d;

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  // single-cycle datapath, arithmetic at WIDTH+1 bits
  always_comb begin
    res  = '0;
    c_f  = 1'b0;
    v_f  = 1'b0;
    ill  = 1'b0;
    wide = '0;
    a_x  = {1'b0, accum};
    b_x  = {1'b0, alu_in};
    case (op)
      OP_NOP:  res = accum;
      OP_PASS: res = alu_in;
      OP_ADD, OP_ADC: begin
        wide = a_x + b_x + {{WIDTH{1'b0}}, (op == OP_ADC) & carry_in};
        res  = wide[WIDTH-1:0];
        c_f  = wide[WIDTH];
        v_f  = (accum[WIDTH-1] == alu_in[WIDTH-1]) && (res[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_SUB: begin
        wide = a_x - b_x;
        res  = wide[WIDTH-1:0];
        c_f  = wide[WIDTH];
        v_f  = (accum[WIDTH-1] != alu_in[WIDTH-1]) && (res[WIDTH-1] != accum[WIDTH-1]);
      end
      OP_AND:  res = accum & alu_in;
      OP_OR:   res = accum | alu_in;
      OP_XOR:  res = accum ^ alu_in;
      OP_SHL: begin
        res = {accum[WIDTH-2:0], 1'b0};
        c_f = accum[WIDTH-1];
      end
      OP_SHR: begin
        res = {1'b0, accum[WIDTH-1:1]};
        c_f = accum[0];
      end
      OP_SAR: begin
        res = {accum[WIDTH-1], accum[WIDTH-1:1]};
        c_f = accum[0];
      end
      // MUL is handled by the iterative path when enabled; otherwise illegal
      default: begin
        res = accum;
        ill = 1'b1;
      end
    endcase

    flags_d        = '0;
    flags_d[FLG_Z] = (res == '0);
    flags_d[FLG_C] = c_f;
    flags_d[FLG_N] = res[WIDTH-1];
    flags_d[FLG_V] = v_f;
    if (ill) flags_d = '0;
  end

`ifdef ALU_MUL_EN
  logic               mul_done;
  logic               mul_take;
  logic [2*WIDTH-1:0] product;
  logic [3:0]         mul_flags;

  assign is_mul   = (op == OP_MUL);
  assign mul_take = (state == BUSY) && mul_done;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst),
    .start   (accept && is_mul),
    .a       (accum),
    .b       (alu_in),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    mul_flags        = '0;
    mul_flags[FLG_Z] = (product[WIDTH-1:0] == '0);
    mul_flags[FLG_C] = (product[2*WIDTH-1:WIDTH] != '0);
    mul_flags[FLG_N] = product[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out_hi <= '0;
    end else if (accept && !is_mul) begin
      alu_out_hi <= '0;
    end else if (mul_take) begin
      alu_out_hi <= product[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign is_mul     = 1'b0;
  assign alu_out_hi = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out <= '0;
      flags   <= '0;
      err     <= 1'b0;
    end else if (accept && !is_mul) begin
      alu_out <= res;
      flags   <= flags_d;
      err     <= ill;
    end
`ifdef ALU_MUL_EN
    else if (mul_take) begin
      alu_out <= product[WIDTH-1:0];
      flags   <= mul_flags;
      err     <= 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = is_mul ? BUSY : DONE;
      end
      BUSY: begin
`ifdef ALU_MUL_EN
        if (mul_take) state_next = DONE;
`else
        state_next = IDLE;
`endif
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (accept) state_next = is_mul ? BUSY : DONE;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
